// File: rtl/decode_stage_if.sv
// cpu_pkg shared types and the decode_stage handshake interface.
// master: fetch/execute side; slave: decode_stage.
package cpu_pkg;
  typedef enum logic [3:0] {
    ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND,
    ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL,
    ALU_SRA, ALU_SLT, ALU_SLTU, ALU_PASSB
  } alu_op_t;

  typedef enum logic {
    SRC_A_RS1, SRC_A_PC
  } src_a_sel_t;

  typedef enum logic {
    SRC_B_RS2, SRC_B_IMM
  } src_b_sel_t;

  typedef struct packed {
    alu_op_t    alu_op;
    src_a_sel_t src_a_sel;
    src_b_sel_t src_b_sel;
    logic       reg_write;
  } control_signals_t;
endpackage

interface decode_stage_if #(
  parameter int XLEN = 32
);
  import cpu_pkg::*;

  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [XLEN-1:0]  in_pc;
  logic             out_valid;
  logic             out_ready;
  control_signals_t out_ctrl;
  logic [XLEN-1:0]  out_imm;
  logic [4:0]       out_rs1;
  logic [4:0]       out_rs2;
  logic [4:0]       out_rd;
  logic [XLEN-1:0]  out_pc;
  logic             out_illegal;

  modport master (
    output flush, in_valid, in_instr, in_pc,
    output out_ready,
    input  in_ready, out_valid, out_ctrl,
    input  out_imm, out_rs1, out_rs2, out_rd,
    input  out_pc, out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc,
    input  out_ready,
    output in_ready, out_valid, out_ctrl,
    output out_imm, out_rs1, out_rs2, out_rd,
    output out_pc, out_illegal
  );
endinterface

// File: rtl/decode_stage.sv
// Registered decoder with DEPTH-entry output FIFO and flush.
// DECODE_ILLEGAL_CNT_EN adds a saturating illegal_cnt output.
module decode_stage #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  decode_stage_if.slave bus
`ifdef DECODE_ILLEGAL_CNT_EN
  ,
  output logic [15:0]   illegal_cnt
`endif
);
  import cpu_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    control_signals_t ctrl;
    logic [XLEN-1:0]  imm;
    logic [4:0]       rs1;
    logic [4:0]       rs2;
    logic [4:0]       rd;
    logic [XLEN-1:0]  pc;
    logic             illegal;
  } entry_t;

  logic [6:0] opc;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [4:0] rd;
  logic       is_op;
  logic       is_opi;
  logic       is_lui;
  logic       is_auipc;
  logic       sh_ok;
  logic       ok;

  control_signals_t ctrl;
  logic [XLEN-1:0]  imm;
  entry_t           din;
  entry_t           mem [DEPTH];

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  assign opc      = bus.in_instr[6:0];
  assign rd       = bus.in_instr[11:7];
  assign f3       = bus.in_instr[14:12];
  assign f7       = bus.in_instr[31:25];
  assign is_op    = (opc == 7'b0110011);
  assign is_opi   = (opc == 7'b0010011);
  assign is_lui   = (opc == 7'b0110111);
  assign is_auipc = (opc == 7'b0010111);

  // RV32 has a 5-bit shamt, so instr[25] must be clear
  assign sh_ok = (XLEN == 64) || !bus.in_instr[25];

  always_comb begin
    ok   = 1'b0;
    imm  = '0;
    ctrl = '{
      alu_op:    ALU_NOP,
      src_a_sel: SRC_A_RS1,
      src_b_sel: SRC_B_RS2,
      reg_write: 1'b0
    };
    unique case (1'b1)
      is_op: begin
        ok = 1'b1;
        unique case ({f7, f3})
          10'b0000000_000: ctrl.alu_op = ALU_ADD;
          10'b0100000_000: ctrl.alu_op = ALU_SUB;
          10'b0000000_001: ctrl.alu_op = ALU_SLL;
          10'b0000000_010: ctrl.alu_op = ALU_SLT;
          10'b0000000_011: ctrl.alu_op = ALU_SLTU;
          10'b0000000_100: ctrl.alu_op = ALU_XOR;
          10'b0000000_101: ctrl.alu_op = ALU_SRL;
          10'b0100000_101: ctrl.alu_op = ALU_SRA;
          10'b0000000_110: ctrl.alu_op = ALU_OR;
          10'b0000000_111: ctrl.alu_op = ALU_AND;
          default:         ok = 1'b0;
        endcase
      end
      is_opi: begin
        ok             = 1'b1;
        ctrl.src_b_sel = SRC_B_IMM;
        imm = XLEN'($signed(bus.in_instr[31:20]));
        unique case (f3)
          3'b000: ctrl.alu_op = ALU_ADD;
          3'b010: ctrl.alu_op = ALU_SLT;
          3'b011: ctrl.alu_op = ALU_SLTU;
          3'b100: ctrl.alu_op = ALU_XOR;
          3'b110: ctrl.alu_op = ALU_OR;
          3'b111: ctrl.alu_op = ALU_AND;
          3'b001: begin
            ctrl.alu_op = ALU_SLL;
            ok  = sh_ok && (f7[6:1] == 6'b000000);
            imm = XLEN'(bus.in_instr[25:20]);
          end
          3'b101: begin
            ctrl.alu_op = f7[5] ? ALU_SRA : ALU_SRL;
            ok  = sh_ok && ((f7[6:1] == 6'b000000) ||
                            (f7[6:1] == 6'b010000));
            imm = XLEN'(bus.in_instr[25:20]);
          end
        endcase
      end
      is_lui: begin
        ok             = 1'b1;
        ctrl.alu_op    = ALU_PASSB;
        ctrl.src_b_sel = SRC_B_IMM;
        imm = XLEN'($signed({bus.in_instr[31:12], 12'b0}));
      end
      is_auipc: begin
        ok             = 1'b1;
        ctrl.alu_op    = ALU_ADD;
        ctrl.src_a_sel = SRC_A_PC;
        ctrl.src_b_sel = SRC_B_IMM;
        imm = XLEN'($signed({bus.in_instr[31:12], 12'b0}));
      end
      default: ;
    endcase
    if (!ok) ctrl.alu_op = ALU_NOP;
    ctrl.reg_write = ok && (rd != 5'd0);
  end

  assign din = '{
    ctrl:    ctrl,
    imm:     imm,
    rs1:     bus.in_instr[19:15],
    rs2:     bus.in_instr[24:20],
    rd:      rd,
    pc:      bus.in_pc,
    illegal: !ok
  };

  assign bus.in_ready  = (count != CW'(DEPTH));
  assign bus.out_valid = (count != '0);

  assign push = bus.in_valid && bus.in_ready && !bus.flush;
  assign pop  = bus.out_valid && bus.out_ready && !bus.flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.flush) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wptr] <= din;
        wptr      <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign bus.out_ctrl    = mem[rptr].ctrl;
  assign bus.out_imm     = mem[rptr].imm;
  assign bus.out_rs1     = mem[rptr].rs1;
  assign bus.out_rs2     = mem[rptr].rs2;
  assign bus.out_rd      = mem[rptr].rd;
  assign bus.out_pc      = mem[rptr].pc;
  assign bus.out_illegal = mem[rptr].illegal;

`ifdef DECODE_ILLEGAL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      illegal_cnt <= '0;
    end else if (push && !ok && (illegal_cnt != 16'hFFFF)) begin
      illegal_cnt <= illegal_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: vector table, hand
// sequences, and random traffic against a mask/match model.
module tb_decode_stage;
  import cpu_pkg::*;

  localparam int XLEN  = 32;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  decode_stage_if #(.XLEN(XLEN)) bus();

`ifdef DECODE_ILLEGAL_CNT_EN
  logic [15:0] illegal_cnt;
`endif

  decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
`ifdef DECODE_ILLEGAL_CNT_EN
    ,
    .illegal_cnt(illegal_cnt)
`endif
  );

  int checks = 0;
  int errs   = 0;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction patterns in riscv-opcodes mask/match form
  typedef struct {
    logic [31:0] mask;
    logic [31:0] match;
    alu_op_t     alu;
    bit          a_pc;
    bit          b_imm;
    int          kind;
  } pat_t;
  pat_t pats[$];

  function automatic void add(input logic [31:0] m,
                              input logic [31:0] v,
                              input alu_op_t a,
                              input bit apc, input bit bim,
                              input int k);
    pats.push_back('{m, v, a, apc, bim, k});
  endfunction

  function automatic void build_pats();
    logic [31:0] sm;
    sm = 32'hFC00707F | ((XLEN == 32) ? 32'h02000000 : 32'h0);
    add(32'hFE00707F, 32'h00000033, ALU_ADD, 0, 0, 0);
    add(32'hFE00707F, 32'h40000033, ALU_SUB, 0, 0, 0);
    add(32'hFE00707F, 32'h00001033, ALU_SLL, 0, 0, 0);
    add(32'hFE00707F, 32'h00002033, ALU_SLT, 0, 0, 0);
    add(32'hFE00707F, 32'h00003033, ALU_SLTU, 0, 0, 0);
    add(32'hFE00707F, 32'h00004033, ALU_XOR, 0, 0, 0);
    add(32'hFE00707F, 32'h00005033, ALU_SRL, 0, 0, 0);
    add(32'hFE00707F, 32'h40005033, ALU_SRA, 0, 0, 0);
    add(32'hFE00707F, 32'h00006033, ALU_OR, 0, 0, 0);
    add(32'hFE00707F, 32'h00007033, ALU_AND, 0, 0, 0);
    add(32'h0000707F, 32'h00000013, ALU_ADD, 0, 1, 1);
    add(32'h0000707F, 32'h00002013, ALU_SLT, 0, 1, 1);
    add(32'h0000707F, 32'h00003013, ALU_SLTU, 0, 1, 1);
    add(32'h0000707F, 32'h00004013, ALU_XOR, 0, 1, 1);
    add(32'h0000707F, 32'h00006013, ALU_OR, 0, 1, 1);
    add(32'h0000707F, 32'h00007013, ALU_AND, 0, 1, 1);
    add(sm, 32'h00001013, ALU_SLL, 0, 1, 2);
    add(sm, 32'h00005013, ALU_SRL, 0, 1, 2);
    add(sm, 32'h40005013, ALU_SRA, 0, 1, 2);
    add(32'h0000007F, 32'h00000037, ALU_PASSB, 0, 1, 3);
    add(32'h0000007F, 32'h00000017, ALU_ADD, 1, 1, 3);
  endfunction

  function automatic void ref_dec(input logic [31:0] ins,
                                  output alu_op_t alu,
                                  output bit a_pc,
                                  output bit b_imm,
                                  output bit rw,
                                  output bit ill,
                                  output logic [63:0] imm);
    ill = 1; alu = ALU_NOP; a_pc = 0; b_imm = 0;
    rw = 0; imm = '0;
    foreach (pats[i]) begin
      if ((ins & pats[i].mask) == pats[i].match) begin
        ill   = 0;
        alu   = pats[i].alu;
        a_pc  = pats[i].a_pc;
        b_imm = pats[i].b_imm;
        rw    = (ins[11:7] != 5'd0);
        case (pats[i].kind)
          1: imm = {{52{ins[31]}}, ins[31:20]};
          2: imm = {58'b0, ins[25:20]};
          3: imm = {{32{ins[31]}}, ins[31:12], 12'b0};
          default: imm = '0;
        endcase
      end
    end
  endfunction

  typedef struct {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
  } beat_t;
  beat_t q[$];
  int    mcnt = 0;

  // Check outputs against the model, then advance one clock
  task automatic cyc();
    alu_op_t     alu;
    bit          apc, bim, rw, ill, pu, po;
    logic [63:0] imm;
    #4;
    chk("out_valid", bus.out_valid, q.size() > 0);
    chk("in_ready", bus.in_ready, q.size() < DEPTH);
    if (q.size() > 0) begin
      ref_dec(q[0].instr, alu, apc, bim, rw, ill, imm);
      chk("pc", bus.out_pc, q[0].pc);
      chk("illegal", bus.out_illegal, ill);
      chk("alu_op", bus.out_ctrl.alu_op, alu);
      chk("reg_write", bus.out_ctrl.reg_write, rw);
      chk("regs", {bus.out_rs1, bus.out_rs2, bus.out_rd},
          {q[0].instr[19:15], q[0].instr[24:20],
           q[0].instr[11:7]});
      if (!ill) begin
        chk("src_a", bus.out_ctrl.src_a_sel, apc);
        chk("src_b", bus.out_ctrl.src_b_sel, bim);
        chk("imm", bus.out_imm, imm[XLEN-1:0]);
      end
    end
`ifdef DECODE_ILLEGAL_CNT_EN
    chk("illegal_cnt", illegal_cnt, mcnt);
`endif
    if (rst) begin
      q.delete();
      mcnt = 0;
    end else if (bus.flush) begin
      q.delete();
    end else begin
      pu = bus.in_valid && (q.size() < DEPTH);
      po = (q.size() > 0) && bus.out_ready;
      if (pu) begin
        ref_dec(bus.in_instr, alu, apc, bim, rw, ill, imm);
        if (ill && mcnt < 65535) mcnt++;
      end
      if (po) void'(q.pop_front());
      if (pu) q.push_back('{bus.in_instr, bus.in_pc});
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] instr;
    alu_op_t     alu;
    bit          a_pc;
    bit          b_imm;
    logic [63:0] imm;
    bit          rw;
    bit          ill;
  } vec_t;
  vec_t vt[$];

  function automatic logic [31:0] gen();
    int          r;
    int          k;
    logic [31:0] ins;
    r = $urandom % 10;
    k = $urandom % pats.size();
    ins = pats[k].match | ($urandom & ~pats[k].mask);
    if (r == 7) ins ^= 32'h1 << (25 + $urandom % 7);
    if (r >= 8) ins = $urandom;
    return ins;
  endfunction

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] got[$];
  int              idx;
  bit              acc;
  bit              seen;

  initial begin
    build_pats();
    vt.push_back('{32'h00500093, ALU_ADD, 0, 1, 64'd5, 1, 0});
    vt.push_back('{32'h402081B3, ALU_SUB, 0, 0, 64'd0, 1, 0});
    vt.push_back('{32'h4030D093, ALU_SRA, 0, 1, 64'd3, 1, 0});
    vt.push_back('{32'hFFF00093, ALU_ADD, 0, 1, '1, 1, 0});
    vt.push_back('{32'h123452B7, ALU_PASSB, 0, 1,
                   64'h12345000, 1, 0});
    vt.push_back('{32'hFFFFFFFF, ALU_NOP, 0, 0, 64'd0, 0, 1});
    vt.push_back('{32'h80000397, ALU_ADD, 1, 1,
                   64'hFFFFFFFF80000000, 1, 0});
    vt.push_back('{32'h00208033, ALU_ADD, 0, 0, 64'd0, 0, 0});
    vt.push_back('{32'hFFE1B113, ALU_SLTU, 0, 1,
                   64'hFFFFFFFFFFFFFFFE, 1, 0});
    vt.push_back('{32'h022080B3, ALU_NOP, 0, 0, 64'd0, 0, 1});
    vt.push_back('{32'h2030D093, ALU_NOP, 0, 0, 64'd0, 0, 1});
    vt.push_back('{32'h02109093,
                   (XLEN == 32) ? ALU_NOP : ALU_SLL, 0, 1,
                   64'd33, XLEN != 32, XLEN == 32});

    bus.flush     = 0;
    bus.in_valid  = 0;
    bus.in_instr  = '0;
    bus.in_pc     = '0;
    bus.out_ready = 0;
    rst = 1;
    pc  = XLEN'(32'h1000);
    @(posedge clk);
    #1;
    cyc();
    rst = 0;

    foreach (vt[i]) begin
      bus.in_valid  = 1;
      bus.in_instr  = vt[i].instr;
      bus.in_pc     = pc;
      bus.out_ready = 1;
      pc += 4;
      cyc();
      bus.in_valid = 0;
      chk("vec_valid", bus.out_valid, 1);
      chk("vec_alu", bus.out_ctrl.alu_op, vt[i].alu);
      chk("vec_ill", bus.out_illegal, vt[i].ill);
      chk("vec_rw", bus.out_ctrl.reg_write, vt[i].rw);
      if (!vt[i].ill) begin
        chk("vec_srca", bus.out_ctrl.src_a_sel, vt[i].a_pc);
        chk("vec_srcb", bus.out_ctrl.src_b_sel, vt[i].b_imm);
        chk("vec_imm", bus.out_imm, vt[i].imm[XLEN-1:0]);
      end
      cyc();
    end

    // Backpressure: three beats into a two-entry FIFO
    bus.out_ready = 0;
    idx = 0;
    for (int c = 0; c < 4; c++) begin
      bus.in_valid = 1;
      bus.in_instr = 32'h00000093 | (32'(idx) << 20);
      bus.in_pc    = XLEN'(100 + 4 * idx);
      acc = bus.in_ready;
      cyc();
      if (acc) idx++;
      if (c == 1) chk("bp_in_ready", bus.in_ready, 0);
    end
    chk("bp_accepted", idx, 2);
    bus.out_ready = 1;
    for (int c = 0; c < 20 && got.size() < 3; c++) begin
      bus.in_valid = (idx < 3);
      bus.in_instr = 32'h00000093 | (32'(idx) << 20);
      bus.in_pc    = XLEN'(100 + 4 * idx);
      acc = bus.in_ready && (idx < 3);
      if (bus.out_valid) got.push_back(bus.out_pc);
      cyc();
      if (acc) idx++;
    end
    bus.in_valid = 0;
    chk("bp_drained", got.size(), 3);
    foreach (got[i]) chk("bp_order", got[i], 100 + 4 * i);

    // Flush with two entries held and a beat offered
    for (int s = 0; s < 2; s++) begin
      bus.out_ready = 0;
      for (int c = 0; c < 2; c++) begin
        bus.in_valid = 1;
        bus.in_instr = 32'h00100113;
        bus.in_pc    = XLEN'(200 + 4 * c);
        cyc();
      end
      chk("pre_full", bus.in_ready, 0);
      bus.in_pc    = XLEN'(32'hDEAD);
      bus.flush    = (s == 0);
      rst          = (s == 1);
      cyc();
      bus.flush    = 0;
      rst          = 0;
      bus.in_valid = 0;
      chk("drop_valid", bus.out_valid, 0);
      chk("drop_ready", bus.in_ready, 1);
      bus.out_ready = 1;
      seen = 0;
      for (int c = 0; c < 3; c++) begin
        if (bus.out_valid && bus.out_pc == XLEN'(32'hDEAD))
          seen = 1;
        cyc();
      end
      chk("drop_gone", seen, 0);
    end

    for (int c = 0; c < 3000; c++) begin
      bus.in_valid  = ($urandom % 4) != 0;
      bus.out_ready = ($urandom % 3) != 0;
      bus.flush     = ($urandom % 50) == 0;
      rst           = ($urandom % 200) == 0;
      bus.in_instr  = gen();
      bus.in_pc     = XLEN'($urandom);
      cyc();
    end
    rst = 0;
    bus.flush = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             checks, errs);
    $finish;
  end
endmodule
